// File: rtl/adc_scan_seq_pkg.sv
// Shared state encoding and command-word constants for the ADC scan sequencer.
package adc_scan_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_REQ    = 3'd2,
      ST_XFER   = 3'd3,
      ST_STORE  = 3'd4,
      ST_WAIT   = 3'd5
   } state_e;

   localparam int          CMD_START_BIT  = 10;
   localparam int          CMD_SINGLE_BIT = 9;
   localparam logic [15:0] TIMEOUT_MARK   = 16'hFFFF;

   function automatic logic [15:0] cmd_word(input logic [2:0] ch);
      logic [15:0] w;
      w                 = '0;
      w[CMD_START_BIT]  = 1'b1;
      w[CMD_SINGLE_BIT] = 1'b1;
      w[8:6]            = ch;
      return w;
   endfunction

endpackage

// File: rtl/adc_result_regs.sv
// Per-channel result storage: one write port, one registered read port.
module adc_result_regs #(
   parameter  int NUM_CH = 8,
   localparam int AW     = $clog2(NUM_CH)
) (
   input  logic          clk,
   input  logic          resn,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [15:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [15:0]   rdata_o
);

   logic [15:0] mem_q [NUM_CH];
   logic [15:0] rdata_q;

   // Read samples the pre-write contents, so a same-cycle store reads old data.
   always_ff @(posedge clk or negedge resn) begin
      if (!resn) begin
         for (int i = 0; i < NUM_CH; i++) mem_q[i] <= '0;
         rdata_q <= '0;
      end else begin
         if (we_i) mem_q[waddr_i] <= wdata_i;
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_scan_seq.sv
// ADC channel scan sequencer driving an SPI engine.
// Optional handshake timeout enabled by defining ADC_SEQ_TIMEOUT_EN.
module adc_scan_seq
   import adc_scan_seq_pkg::*;
#(
   parameter  int NUM_CH         = 8,
   parameter  int TIMEOUT_CYCLES = 4096,
   localparam int AW             = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              resn,
   input  logic              enable,
   input  logic              oneShot,
   input  logic [NUM_CH-1:0] chanMask,
   input  logic [15:0]       interval,
   output logic              spiTrig,
   output logic [15:0]       spiWrData,
   input  logic              spiDone,
   input  logic [15:0]       spiRdData,
   input  logic [AW-1:0]     rdAddr,
   output logic [15:0]       rdResult,
   output logic              busy,
   output logic              scanDone,
   output logic              timeoutErr,
   input  logic              errClr
);

   state_e            state_q, state_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [2:0]        ch_q, ch_d;
   logic [15:0]       wait_q, wait_d;
   logic              done_q, done_d;
   logic              we;
   logic [15:0]       wdata;
   logic              pend;
   logic [2:0]        pend_ch;
   logic              tmo_hit;
   logic              unused_hi;

   assign unused_hi = ^spiRdData[15:12];

   always_comb begin
      pend    = 1'b0;
      pend_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            pend    = 1'b1;
            pend_ch = 3'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      ch_d    = ch_q;
      wait_d  = wait_q;
      done_d  = 1'b0;
      we      = 1'b0;
      wdata   = {4'b0, spiRdData[11:0]};
      unique case (state_q)
         ST_IDLE: begin
            if (enable || oneShot) begin
               state_d = ST_SELECT;
               mask_d  = chanMask;
               ch_d    = '0;
            end
         end
         ST_SELECT: begin
            if (pend) begin
               state_d = ST_REQ;
               ch_d    = pend_ch;
               mask_d  = mask_q & (mask_q - {{(NUM_CH-1){1'b0}}, 1'b1});
            end else begin
               done_d = 1'b1;
               if (!enable) begin
                  state_d = ST_IDLE;
               end else if (interval == 16'd0) begin
                  mask_d = chanMask;
               end else begin
                  state_d = ST_WAIT;
                  wait_d  = 16'd1;
               end
            end
         end
         ST_REQ, ST_XFER: begin
            if (tmo_hit) begin
               we      = 1'b1;
               wdata   = TIMEOUT_MARK;
               state_d = ST_SELECT;
            end else if (state_q == ST_REQ && !spiDone) begin
               state_d = ST_XFER;
            end else if (state_q == ST_XFER && spiDone) begin
               state_d = ST_STORE;
            end
         end
         ST_STORE: begin
            we      = 1'b1;
            state_d = ST_SELECT;
         end
         ST_WAIT: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (wait_q >= interval) begin
               state_d = ST_SELECT;
               mask_d  = chanMask;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resn) begin
      if (!resn) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         ch_q    <= '0;
         wait_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         ch_q    <= ch_d;
         wait_q  <= wait_d;
         done_q  <= done_d;
      end
   end

`ifdef ADC_SEQ_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;
   logic        err_q, err_d;

   assign tmo_hit = (state_q == ST_REQ || state_q == ST_XFER) &&
                    (tmo_q == 32'(TIMEOUT_CYCLES - 1));

   // Counter restarts on every phase change, so REQ and XFER are timed separately.
   always_comb begin
      tmo_d = '0;
      if ((state_q == ST_REQ || state_q == ST_XFER) && state_d == state_q)
         tmo_d = tmo_q + 32'd1;
      err_d = err_q;
      if (errClr) err_d = 1'b0;
      if (tmo_hit) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge resn) begin
      if (!resn) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign timeoutErr = err_q;
`else
   logic unused_cfg;

   assign tmo_hit    = 1'b0;
   assign timeoutErr = 1'b0;
   assign unused_cfg = errClr ^ (TIMEOUT_CYCLES > 0);
`endif

   assign spiTrig   = (state_q == ST_REQ);
   assign spiWrData = spiTrig ? cmd_word(ch_q) : 16'h0000;
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_WAIT);
   assign scanDone  = done_q;

   adc_result_regs #(.NUM_CH(NUM_CH)) u_regs (
      .clk     (clk),
      .resn    (resn),
      .we_i    (we),
      .waddr_i (ch_q[AW-1:0]),
      .wdata_i (wdata),
      .raddr_i (rdAddr),
      .rdata_o (rdResult)
   );

endmodule

// File: tb/tb_adc_scan_seq.sv
// Scoreboard bench for adc_scan_seq with a behavioural SPI engine model.
module tb_adc_scan_seq;

   logic        clk = 1'b0;
   logic        resn = 1'b0;
   logic        enable = 1'b0;
   logic        oneShot = 1'b0;
   logic [7:0]  chanMask = '0;
   logic [15:0] interval = '0;
   logic        spiTrig;
   logic [15:0] spiWrData;
   logic        spiDone = 1'b1;
   logic [15:0] spiRdData = '0;
   logic [2:0]  rdAddr = '0;
   logic [15:0] rdResult;
   logic        busy, scanDone, timeoutErr;
   logic        errClr = 1'b0;

   int n_tests = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int trig_cnt = 0;
   int idle_cnt = 0;
   logic prev_trig = 1'b0;
   int spi_mode = 0;
   logic fixed_en = 1'b0;

   logic [15:0] cmd_q [$];
   int          gap_q [$];
   logic [15:0] ret_q [$];
   logic [15:0] exp_res [8];

   adc_scan_seq dut (
      .clk        (clk),
      .resn       (resn),
      .enable     (enable),
      .oneShot    (oneShot),
      .chanMask   (chanMask),
      .interval   (interval),
      .spiTrig    (spiTrig),
      .spiWrData  (spiWrData),
      .spiDone    (spiDone),
      .spiRdData  (spiRdData),
      .rdAddr     (rdAddr),
      .rdResult   (rdResult),
      .busy       (busy),
      .scanDone   (scanDone),
      .timeoutErr (timeoutErr),
      .errClr     (errClr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_cmd(input int ch);
      return 16'h0600 + 16'(ch) * 16'd64;
   endfunction

   // SPI engine: mode 0 normal, 1 never answers, 2 starts a frame and hangs.
   initial begin : spi_model
      logic [15:0] d;
      int n;
      forever begin
         @(negedge clk);
         if (spiTrig === 1'b1 && spi_mode != 1) begin
            n = $urandom_range(0, 2);
            repeat (n) @(negedge clk);
            @(posedge clk);
            #1 spiDone = 1'b0;
            if (spi_mode == 0) begin
               d = fixed_en ? 16'h0ABC : 16'($urandom);
               n = $urandom_range(1, 4);
               repeat (n) @(posedge clk);
               #1 spiRdData = d;
               spiDone = 1'b1;
               ret_q.push_back(d);
            end
         end
      end
   end

   initial begin : monitor
      logic [15:0] e;
      int g;
      forever begin
         @(negedge clk);
         if (spiTrig && !prev_trig) begin
            trig_cnt++;
            if (cmd_q.size() == 0) begin
               check("trig_expected", spiWrData, 16'hxxxx);
            end else begin
               e = cmd_q.pop_front();
               check("spiWrData", spiWrData, e);
            end
            if (gap_q.size() != 0) begin
               g = gap_q.pop_front();
               if (g >= 0) check("scan_gap", idle_cnt, g);
            end
            idle_cnt = 0;
         end
         if (!busy) idle_cnt++;
         if (scanDone) done_cnt++;
         prev_trig = spiTrig;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic start_scan(input logic [7:0] m);
      for (int i = 0; i < 8; i++)
         if (m[i]) cmd_q.push_back(exp_cmd(i));
      @(posedge clk);
      #1 chanMask = m;
      oneShot = 1'b1;
      @(posedge clk);
      #1 oneShot = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, output int n);
      n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         #1 n++;
      end
      check("scan_done_seen", 32'(done_cnt >= target), 1);
   endtask

   task automatic wait_trig(input int target, input int budget);
      int n = 0;
      while (trig_cnt < target && n < budget) begin
         @(negedge clk);
         #1 n++;
      end
      check("trig_seen", 32'(trig_cnt >= target), 1);
   endtask

   task automatic retire(input logic [7:0] m);
      logic [15:0] d;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            if (ret_q.size() == 0) begin
               check("spi_returns", 0, 1);
            end else begin
               d = ret_q.pop_front();
               exp_res[i] = {4'h0, d[11:0]};
            end
         end
      end
   endtask

   task automatic read_res(input int a, output logic [15:0] v);
      @(posedge clk);
      #1 rdAddr = 3'(a);
      @(posedge clk);
      @(negedge clk);
      v = rdResult;
   endtask

   task automatic check_all();
      logic [15:0] v;
      for (int i = 0; i < 8; i++) begin
         read_res(i, v);
         check($sformatf("result[%0d]", i), v, exp_res[i]);
      end
   endtask

   initial begin
      int n, bd, bt;
      logic [7:0] m;
      logic [15:0] v;
      for (int i = 0; i < 8; i++) exp_res[i] = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_spiTrig", spiTrig, 0);
      check("rst_spiWrData", spiWrData, 0);
      check("rst_busy", busy, 0);
      check("rst_scanDone", scanDone, 0);
      check("rst_timeoutErr", timeoutErr, 0);
      check("rst_rdResult", rdResult, 0);
      resn = 1'b1;

      // two-channel scan with fixed engine data
      fixed_en = 1'b1;
      start_scan(8'h05);
      wait_done(1, 300, n);
      repeat (4) @(negedge clk);
      check("single_done_pulse", done_cnt, 1);
      retire(8'h05);
      fixed_en = 1'b0;
      read_res(0, v);
      check("res0_0ABC", v, 16'h0ABC);
      read_res(2, v);
      check("res2_0ABC", v, 16'h0ABC);
      check_all();

      // empty mask: quick completion, no SPI frame
      bt = trig_cnt;
      start_scan(8'h00);
      wait_done(2, 10, n);
      check("empty_latency_le3", 32'(n <= 3), 1);
      check("empty_no_trig", trig_cnt, bt);

      // random scans, with an oneShot while busy that must be ignored
      for (int k = 0; k < 6; k++) begin
         m = 8'($urandom_range(1, 255));
         bd = done_cnt;
         start_scan(m);
         #1 chanMask = 8'($urandom);
         oneShot = 1'b1;
         @(posedge clk);
         #1 oneShot = 1'b0;
         wait_done(bd + 1, 3000, n);
         repeat (6) @(negedge clk);
         check("rand_one_done", done_cnt, bd + 1);
         check("rand_idle", busy, 0);
         retire(m);
         check_all();
      end

      // continuous scanning with idle interval, then enable dropped mid-frame
      bd = done_cnt;
      bt = trig_cnt;
      gap_q.push_back(-1);
      gap_q.push_back(100);
      gap_q.push_back(100);
      for (int i = 0; i < 3; i++) cmd_q.push_back(exp_cmd(0));
      @(posedge clk);
      #1 interval = 16'd100;
      chanMask = 8'h01;
      enable = 1'b1;
      wait_trig(bt + 3, 2000);
      @(posedge clk);
      #1 enable = 1'b0;
      wait_done(bd + 3, 300, n);
      repeat (6) @(negedge clk);
      check("cont_done_count", done_cnt, bd + 3);
      check("cont_trig_count", trig_cnt, bt + 3);
      check("cont_gaps_used", gap_q.size(), 0);
      check("cont_idle_after", busy, 0);
      retire(8'h01);
      retire(8'h01);
      retire(8'h01);
      check_all();

`ifdef ADC_SEQ_TIMEOUT_EN
      // engine never answers: timeout marker and sticky error
      spi_mode = 1;
      bd = done_cnt;
      bt = trig_cnt;
      start_scan(8'h01);
      wait_trig(bt + 1, 20);
      n = 0;
      while (!timeoutErr && n < 5000) begin
         @(negedge clk);
         #1 n++;
      end
      check("timeout_cycles", n, 4096);
      check("timeout_trig_drop", spiTrig, 0);
      wait_done(bd + 1, 20, n);
      exp_res[0] = 16'hFFFF;
      check_all();
      check("timeout_sticky", timeoutErr, 1);
      @(posedge clk);
      #1 errClr = 1'b1;
      @(posedge clk);
      #1 errClr = 1'b0;
      check("timeout_cleared", timeoutErr, 0);
      spi_mode = 0;
`endif

      // reset asserted while a frame is in flight
      spi_mode = 2;
      start_scan(8'h02);
      n = 0;
      while (!(busy && !spiTrig && !spiDone) && n < 100) begin
         @(negedge clk);
         #1 n++;
      end
      check("xfer_reached", 32'(n < 100), 1);
      #1 resn = 1'b0;
      #1;
      check("mid_rst_spiTrig", spiTrig, 0);
      check("mid_rst_spiWrData", spiWrData, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_scanDone", scanDone, 0);
      check("mid_rst_timeoutErr", timeoutErr, 0);
      check("mid_rst_rdResult", rdResult, 0);
      spiDone = 1'b1;
      spi_mode = 0;
      @(posedge clk);
      #1 resn = 1'b1;
      for (int i = 0; i < 8; i++) exp_res[i] = '0;
      check_all();
      check("cmds_consumed", cmd_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_scan_seq.md
ADC_SCAN_SEQ -- requirements
Module: adc_scan_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, meaning number of ADC channels scanned (power of two, 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning clk cycles allowed per SPI handshake phase.
REQ-003 SHALL have port clk, input, 1, meaning system clock; all logic on its rising edge.
REQ-004 SHALL have port resn, input, 1, meaning reset; asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1, meaning continuous scanning while high.
REQ-006 SHALL have port oneShot, input, 1, meaning single-cycle pulse requesting one scan.
REQ-007 SHALL have port chanMask, input, NUM_CH, meaning channel i is scanned when bit i = 1.
REQ-008 SHALL have port interval, input, 16, meaning idle cycles between continuous scans.
REQ-009 SHALL have port spiTrig, output, 1, meaning start request to the SPI engine.
REQ-010 SHALL have port spiWrData, output, 16, meaning command word to the SPI engine.
REQ-011 SHALL have port spiDone, input, 1, meaning engine idle (high) / frame active (low).
REQ-012 SHALL have port spiRdData, input, 16, meaning word shifted in by the engine.
REQ-013 SHALL have port rdAddr, input, log2(NUM_CH), meaning result read select.
REQ-014 SHALL have port rdResult, output, 16, meaning registered result for rdAddr.
REQ-015 SHALL have ports busy (out, 1, scan active), scanDone (out, 1, one-cycle pulse at scan end), timeoutErr (out, 1, sticky error), errClr (in, 1, clears timeoutErr).

Function
REQ-016 SHALL implement FSM states IDLE, SELECT, REQ, XFER, STORE, WAIT.
REQ-017 IDLE SHALL go to SELECT when enable=1 or oneShot=1, latching chanMask into an internal scan mask and setting channel index to 0.
REQ-018 SELECT SHALL advance index to the next masked channel, one channel per cycle, and go to REQ; when none remain it SHALL pulse scanDone and go to WAIT if enable=1, else IDLE.
REQ-019 REQ SHALL hold spiTrig=1 with spiWrData = {5'b0, 1'b1, 1'b1, ch[2:0], 6'b0} until spiDone=0, then drop spiTrig and go to XFER.
REQ-020 XFER SHALL wait for spiDone=1, then go to STORE.
REQ-021 STORE SHALL write {4'b0, spiRdData[11:0]} to result[ch] and return to SELECT.
REQ-022 WAIT SHALL count interval cycles (interval=0 means zero wait cycles) then go to SELECT with a fresh chanMask latch; if enable=0 it SHALL go to IDLE.
REQ-023 chanMask = 0 SHALL complete the scan with scanDone and no SPI transaction.
REQ-024 oneShot while busy SHALL be ignored; enable falling mid-scan SHALL finish the current scan, then go to IDLE.
REQ-025 rdResult SHALL have 1-cycle latency; a read and a STORE to the same address in the same cycle SHALL return the old value.
REQ-026 busy SHALL be 1 in every state except IDLE and WAIT.

Reset
REQ-027 resn low SHALL immediately force IDLE, spiTrig=0, spiWrData=0, busy=0, scanDone=0, timeoutErr=0, rdResult=0, and all results = 0, including mid-transaction.

Configuration
REQ-028 With ADC_SEQ_TIMEOUT_EN defined, REQ or XFER lasting TIMEOUT_CYCLES cycles SHALL set timeoutErr, drop spiTrig, store 16'hFFFF for that channel, and go to SELECT; errClr clears timeoutErr, and a set in the same cycle wins.
REQ-029 Without ADC_SEQ_TIMEOUT_EN, no timeout counter SHALL exist, timeoutErr SHALL be tied 0, and REQ/XFER wait indefinitely.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the command-word start/single bit positions, and the 16'hFFFF timeout marker.
REQ-031 The result register file (write port, registered read port) SHALL be sub-module adc_result_regs.

Verification
REQ-032 chanMask=8'h05, oneShot, SPI model returning 16'h0ABC → spiWrData = 16'h0600 then 16'h0680; result[0] = result[2] = 16'h0ABC; one scanDone pulse.
REQ-033 chanMask=0, oneShot → scanDone within 3 cycles; spiTrig never asserted.
REQ-034 enable=1, interval=100, mask=8'h01 → spiTrig rising edges exactly 100 idle cycles + transaction apart; enable dropped mid-frame → frame completes, then IDLE.
REQ-035 With macro, spiDone stuck high → timeoutErr after 4096 cycles, result = 16'hFFFF; errClr clears it.
REQ-036 resn asserted during XFER → all outputs at reset values same cycle; results read back 0.
